cla_seq_adder: RTL and testbench

Multi-cycle WIDTH-bit add/subtract sequencer that time-shares a single 16-bit two-level carry-lookahead slice. The slice is four `CLA4bits` groups plus one second-level `CLA4bits` on their group PP/GG. The block latches one operand pair through a valid/ready handshake, then walks the slice across the operands least-significant first. A registered carry passes between slices, and the block presents the full sum, carry-out and signed-overflow through an output valid/ready handshake. It is the arithmetic backend for wide-operand datapaths that cannot afford a full-width lookahead tree.

---
 rtl/cla_seq_adder.sv | 175 +++++++++++++++++
 tb/tb_cla_seq_adder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder
//   Multi-cycle WIDTH-bit add/subtract engine. One operand pair is latched
//   through an input valid/ready handshake. A single 16-bit two-level
//   carry-lookahead slice (four 4-bit lookahead groups plus one second-level
//   group) is then applied to the operands, least-significant slice first.
//   A registered carry links consecutive slices. The result is held behind an
//   output valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. Ready never depends combinationally on valid, and valid never
//   depends combinationally on ready. Both in_ready and out_valid are decoded
//   from the state register only.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   block can accept (IDLE only)
//   a, b       operands (WIDTH bits)
//   sub        0: a+b, 1: a-b
//   out_valid  result held and valid (DONE)
//   out_ready  consumer takes the result
//   sum        WIDTH-bit result
//   cout       carry out of the top bit (for sub: 1 = no borrow)
//   ovf        signed overflow
//
// WIDTH must be a multiple of 16 and at least 32.
module cla_seq_adder #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 16;
    localparam int IDX_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r, b_r;
    logic             carry_r;
    logic             last;

    // Slice datapath
    logic [15:0] a_s, b_s, p_s, g_s, c_bits, s_s;
    logic [3:0]  grp_p, grp_g, grp_c;
    logic [5:0]  lvl, top;
    logic        c_s;

    // 4-bit lookahead group: returns {PP, GG, c3, c2, c1, c0}
    function automatic logic [5:0] cla4(input logic [3:0] p, input logic [3:0] g,
                                        input logic c0);
        logic c1, c2, c3, pp, gg;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        pp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {pp, gg, c3, c2, c1, c0};
    endfunction

    assign last = (idx == IDX_W'(NSLICE - 1));

    // Select the active 16-bit field of the latched operands
    always_comb begin
        a_s = '0;
        b_s = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                a_s = a_r[i*16 +: 16];
                b_s = b_r[i*16 +: 16];
            end
        end
    end

    // Two-level lookahead: group PP/GG first (independent of carry-in),
    // then the second level produces each group's carry-in, then bit carries.
    always_comb begin
        p_s    = a_s ^ b_s;
        g_s    = a_s & b_s;
        grp_p  = '0;
        grp_g  = '0;
        c_bits = '0;
        lvl    = '0;
        for (int j = 0; j < 4; j++) begin
            lvl      = cla4(p_s[j*4 +: 4], g_s[j*4 +: 4], 1'b0);
            grp_p[j] = lvl[5];
            grp_g[j] = lvl[4];
        end
        top   = cla4(grp_p, grp_g, carry_r);
        grp_c = top[3:0];
        for (int j = 0; j < 4; j++) begin
            lvl              = cla4(p_s[j*4 +: 4], g_s[j*4 +: 4], grp_c[j]);
            c_bits[j*4 +: 4] = lvl[3:0];
        end
        s_s = p_s ^ c_bits;
        c_s = top[4] | (top[5] & carry_r);
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1: invert b, seed carry with 1
                        a_r     <= a;
                        b_r     <= sub ? ~b : b;
                        carry_r <= sub;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NSLICE; i++) begin
                        if (idx == IDX_W'(i)) sum[i*16 +: 16] <= s_s;
                    end
                    carry_r <= c_s;
                    if (last) begin
                        cout <= c_s;
                        // Uses the already-inverted b, so add and sub share the rule
                        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s_s[15] != a_r[WIDTH-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
module tb_cla_seq_adder;
    localparam int W  = 64;
    localparam int NS = W / 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    // Scoreboard entries are {ovf, cout, sum}
    logic [W+1:0] exp_q[$];
    int run_left = 0;
    bit holding  = 1'b0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int last_acc = -1;
    bit b2b      = 1'b0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    task automatic chk(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference arithmetic: plain wide add / subtract with unsigned compare for borrow
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
        logic [W-1:0] r;
        logic c, o;
        if (s) begin
            r = x - y;
            c = (x >= y);
            o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        end else begin
            {c, r} = {1'b0, x} + {1'b0, y};
            o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
        end
        return {o, c, r};
    endfunction

    // Transaction-level model: an accepted op is busy NS cycles, then held
    // until out_ready; the block accepts only when neither busy nor holding.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            run_left = 0;
            holding  = 1'b0;
        end else begin
            cyc++;
            if (holding) begin
                if (out_ready) begin
                    holding = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else if (run_left > 0) begin
                run_left--;
                if (run_left == 0) holding = 1'b1;
            end else if (in_valid) begin
                exp_q.push_back(ref_op(a, b, sub));
                run_left = NS;
                acc_cnt++;
                if (b2b && last_acc >= 0) chk("accept_spacing", cyc - last_acc, NS + 2);
                last_acc = cyc;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", in_ready, (run_left == 0 && !holding));
            chk("out_valid", out_valid, holding);
            if (holding) begin
                if (exp_q.size() == 0) chk("exp_q_size", exp_q.size(), 1);
                else chk("result", {ovf, cout, sum}, exp_q[0]);
            end
        end
    end

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_in_ready"}, in_ready, 1'b1);
        a = ta; b = tbv; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble operands after accept; they must not affect the result
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sub = ~ts;
        wait_out(n);
        chk({nm, "_latency"}, n, NS);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int start;

        // Pin the reference model with hand-computed values
        chk("model_wrap",   ref_op('1, 64'd1, 1'b0), {1'b0, 1'b1, 64'h0});
        chk("model_borrow", ref_op('0, 64'd1, 1'b1), {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        chk("model_ovf_add", ref_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0),
            {1'b1, 1'b0, 64'h8000_0000_0000_0000});
        chk("model_ovf_sub", ref_op(64'h8000_0000_0000_0000, 64'd1, 1'b1),
            {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        do_op('1, 64'd1, 1'b0, 64'h0, 1'b1, 1'b0, "wrap");
        do_op('0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "borrow");
        do_op(64'd5, 64'd5, 1'b1, 64'h0, 1'b1, 1'b0, "sub_equal");
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, "ovf_add");
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, "ovf_sub");

        // Backpressure: hold DONE for 5 cycles while poking inputs
        a = 64'd1; b = 64'd2; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        chk("bp_latency", n, NS);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_result", {ovf, cout, sum}, {2'b00, 64'd3});
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            in_valid = i[0];
            @(posedge clk); #1;
        end
        chk("bp_hold_result", {ovf, cout, sum}, {2'b00, 64'd3});
        a = 64'd10; b = 64'd20; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1'b1);
        chk("bp_idle_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("bp_accepted", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_out(n);
        chk("bp2_latency", n, NS);
        chk("bp2_sum", sum, 64'd30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset in the middle of RUN (after two slices written)
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_sum", sum, '0);
        chk("midrst_cout", cout, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
              64'h2222_2222_2222_2211, 1'b0, 1'b0, "fresh");

        // Back-to-back with both handshakes tied high
        last_acc = -1;
        b2b = 1'b1;
        start = acc_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1;
        n = 0;
        while (acc_cnt < start + 100 && n < 2000) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        b2b = 1'b0;
        chk("b2b_accepts", acc_cnt - start, 100);
        n = 0;
        while ((out_valid || !in_ready) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_idle", {out_valid, in_ready}, 2'b01);
        chk("drain_queue", exp_q.size(), 0);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
